// File: rtl/game_timer_pkg.sv
// Shared constants for the game timer: state encodings seen on the state port.
package game_timer_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;

endpackage

// File: rtl/game_timer_if.sv
// Control/status bundle between a game controller (master) and the timer (slave).
interface game_timer_if #(
  parameter int unsigned SEC_W = 8
);

  logic             start;
  logic [SEC_W-1:0] load_val;
  logic             pause;
  logic             abort;
  logic             add_en;
  logic [SEC_W-1:0] add_val;
  logic             tick;
  logic [SEC_W-1:0] remaining;
  logic             expired;
  logic [1:0]       state;
  logic             warn;

  modport master (
    output start, load_val, pause, abort, add_en, add_val,
    input  tick, remaining, expired, state, warn
  );

  modport slave (
    input  start, load_val, pause, abort, add_en, add_val,
    output tick, remaining, expired, state, warn
  );

endinterface

// File: rtl/game_timer_prescaler.sv
// Clock prescaler: counts enabled cycles and pulses tick on the last one of every DIV.
module tick_prescaler #(
  parameter int unsigned DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W    = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count enabled cycles, wrapping on the tick cycle; clear has priority over counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/game_timer.sv
// Countdown game timer with pause, abort, bonus time, low-time warning and expiry pulse.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned DIV      = 100000000,
  parameter int unsigned SEC_W    = 8,
  parameter int unsigned MAX_SEC  = 255,
  parameter int unsigned WARN_SEC = 10
) (
  input  logic          clk,
  input  logic          rst,
  game_timer_if.slave   bus
);

  localparam logic [SEC_W:0] MAX_W = (SEC_W + 1)'(MAX_SEC);

  logic [1:0]       state_q, state_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic             exp_q, exp_d;
  logic             live, pre_en, pre_clr, tick;
  logic [SEC_W:0]   load_c, tick_w, sum_c, nxt;

  // Prescaler runs only while actually running; abort/start in the same cycle suppress the tick.
  assign live    = (state_q == RUN) || (state_q == PAUSED);
  assign pre_en  = (state_q == RUN) && !bus.pause && !bus.abort && !bus.start;
  assign pre_clr = bus.abort || bus.start || !live;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  // Next state/remaining: abort > start > add_en > tick, arithmetic one bit wider to saturate.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    exp_d   = 1'b0;
    load_c  = {1'b0, bus.load_val};
    if (load_c > MAX_W) load_c = MAX_W;
    tick_w  = {{SEC_W{1'b0}}, tick};
    sum_c   = {1'b0, rem_q} + {1'b0, bus.add_val} - tick_w;
    if (sum_c > MAX_W) sum_c = MAX_W;
    nxt     = bus.add_en ? sum_c : ({1'b0, rem_q} - tick_w);

    if (bus.abort) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (bus.start) begin
      if (load_c == '0) begin
        state_d = EXPIRED;
        rem_d   = '0;
        exp_d   = 1'b1;
      end else begin
        state_d = RUN;
        rem_d   = load_c[SEC_W-1:0];
      end
    end else if (live) begin
      if ((bus.add_en || tick) && (nxt == '0)) begin
        state_d = EXPIRED;
        rem_d   = '0;
        exp_d   = 1'b1;
      end else begin
        rem_d = nxt[SEC_W-1:0];
        if ((state_q == RUN) && bus.pause) begin
          state_d = PAUSED;
        end else if ((state_q == PAUSED) && !bus.pause) begin
          state_d = RUN;
        end
      end
    end
  end

  // State, remaining and expiry pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.tick      = tick;
  assign bus.remaining = rem_q;
  assign bus.expired   = exp_q;
  assign bus.state     = state_q;
  assign bus.warn      = live && (rem_q != '0) && (32'(rem_q) <= WARN_SEC);

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: rule-level model compared every cycle plus directed pins.
module tb_game_timer;

  localparam int DIV   = 4;
  localparam int SEC_W = 4;
  localparam int MAXS  = 6;
  localparam int WARN  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_timer_if #(.SEC_W(SEC_W)) bus ();

  game_timer #(.DIV(DIV), .SEC_W(SEC_W), .MAX_SEC(MAXS), .WARN_SEC(WARN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  function automatic void check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: state 0 idle, 1 run, 2 paused, 3 expired; elapsed counts run cycles since last tick.
  int m_state = 0;
  int m_rem   = 0;
  int elapsed = 0;
  int m_exp   = 0;

  function automatic int m_tick();
    return (m_state == 1 && !bus.pause && !bus.abort && !bus.start && elapsed == DIV - 1) ? 1 : 0;
  endfunction

  function automatic int m_warn();
    return ((m_state == 1 || m_state == 2) && m_rem > 0 && m_rem <= WARN) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    int t, v, nr;
    bit live;
    if (!rst) begin
      m_state = 0; m_rem = 0; elapsed = 0; m_exp = 0;
    end else begin
      t = m_tick();
      live = (m_state == 1 || m_state == 2);
      m_exp = 0;
      if (bus.abort) begin
        m_state = 0; m_rem = 0; elapsed = 0;
      end else if (bus.start) begin
        v = (int'(bus.load_val) > MAXS) ? MAXS : int'(bus.load_val);
        elapsed = 0;
        m_rem = v;
        if (v == 0) begin m_state = 3; m_exp = 1; end
        else m_state = 1;
      end else begin
        if (m_state == 1 && !bus.pause) elapsed = (elapsed + 1) % DIV;
        else if (!live) elapsed = 0;
        nr = m_rem;
        if (live && bus.add_en) begin
          nr = m_rem + int'(bus.add_val) - t;
          if (nr > MAXS) nr = MAXS;
        end else nr = m_rem - t;
        if (live && (t == 1 || bus.add_en) && nr == 0) begin
          m_state = 3; m_rem = 0; m_exp = 1;
        end else begin
          m_rem = nr;
          if (m_state == 1 && bus.pause) m_state = 2;
          else if (m_state == 2 && !bus.pause) m_state = 1;
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge once the bench is under way.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("tick",      int'(bus.tick),      m_tick());
      check("remaining", int'(bus.remaining), m_rem);
      check("expired",   int'(bus.expired),   m_exp);
      check("state",     int'(bus.state),     m_state);
      check("warn",      int'(bus.warn),      m_warn());
    end
  end

  // Per-scenario record of DUT outputs, indexed by cycle since the scenario's first step.
  int k;
  int tk[0:39];
  int rm[0:39];
  int ex[0:39];
  int stv[0:39];
  int wn[0:39];

  task automatic step(input logic st, input int lv, input logic pz,
                      input logic ab, input logic ae, input int av);
    @(posedge clk);
    #1;
    bus.start    = st;
    bus.load_val = SEC_W'(lv);
    bus.pause    = pz;
    bus.abort    = ab;
    bus.add_en   = ae;
    bus.add_val  = SEC_W'(av);
    @(negedge clk);
    tk[k]  = int'(bus.tick);
    rm[k]  = int'(bus.remaining);
    ex[k]  = int'(bus.expired);
    stv[k] = int'(bus.state);
    wn[k]  = int'(bus.warn);
    if (k < 39) k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic begin_run(input int lv);
    k = 0;
    step(1'b1, lv, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.load_val = '0; bus.pause = 1'b0;
    bus.abort = 1'b0; bus.add_en = 1'b0; bus.add_val = '0;
    #2 rst = 1'b0;
    #1;
    cmp_on = 1'b1;
    check("rst_state",   int'(bus.state),     0);
    check("rst_rem",     int'(bus.remaining), 0);
    check("rst_expired", int'(bus.expired),   0);
    check("rst_tick",    int'(bus.tick),      0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;

    // Basic countdown from 3
    begin_run(3); idle(14);
    check("s1_rem_c1",  rm[1], 3);
    check("s1_warn_c1", wn[1], 0);
    check("s1_tick_c3", tk[3], 0);
    check("s1_tick_c4", tk[4], 1);
    check("s1_rem_c5",  rm[5], 2);
    check("s1_warn_c5", wn[5], 1);
    check("s1_tick_c8", tk[8], 1);
    check("s1_tick_c12", tk[12], 1);
    check("s1_exp_c13", ex[13], 1);
    check("s1_st_c13",  stv[13], 3);
    check("s1_exp_c14", ex[14], 0);
    check("s1_warn_c14", wn[14], 0);

    // Pause held for five cycles starting at cycle 3
    begin_run(5);
    for (int c = 1; c <= 16; c++) step(1'b0, 0, (c >= 3 && c <= 7), 1'b0, 1'b0, 0);
    check("s2_st_c4",  stv[4], 2);
    check("s2_tick_c4", tk[4], 0);
    check("s2_rem_c7", rm[7], 5);
    check("s2_st_c9",  stv[9], 1);
    check("s2_rem_c11", rm[11], 4);

    // Bonus time with saturation, then bonus on a tick cycle
    begin_run(2); idle(1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 9);
    idle(1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 15);
    idle(1);
    check("s3_rem_sat", rm[3], 6);
    check("s3_tick_c4", tk[4], 1);
    check("s3_rem_c5",  rm[5], 6);

    begin_run(3); idle(7);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1);
    idle(1);
    check("s3_tick_c8", tk[8], 1);
    check("s3_rem_c9",  rm[9], 2);

    // Tick plus zero bonus on the last second expires
    begin_run(1); idle(3);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 0);
    idle(2);
    check("s3_exp_c5", ex[5], 1);
    check("s3_st_c5",  stv[5], 3);
    check("s3_exp_c6", ex[6], 0);

    // Abort beats start; bonus in IDLE ignored; zero load expires; oversize load clamps
    begin_run(4); idle(1);
    step(1'b1, 5, 1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 5);
    idle(1);
    check("s4_tick_c2", tk[2], 0);
    check("s4_st_c3",  stv[3], 0);
    check("s4_rem_c3", rm[3], 0);
    check("s4_rem_c4", rm[4], 0);

    begin_run(0); idle(3);
    check("s4_st_c1",  stv[1], 3);
    check("s4_exp_c1", ex[1], 1);
    check("s4_exp_c2", ex[2], 0);
    check("s4_tick_z", tk[3], 0);

    begin_run(9); idle(1);
    check("s4_clamp", rm[1], 6);

    // Asynchronous reset mid-run, then a normal run
    begin_run(4); idle(2);
    check("s5_rem_pre", rm[2], 4);
    #2 rst = 1'b0;
    #1;
    check("s5_async_st",   int'(bus.state),     0);
    check("s5_async_rem",  int'(bus.remaining), 0);
    check("s5_async_tick", int'(bus.tick),      0);
    check("s5_async_exp",  int'(bus.expired),   0);
    check("s5_async_warn", int'(bus.warn),      0);
    idle(2);
    @(posedge clk);
    #1 rst = 1'b1;
    begin_run(2); idle(10);
    check("s5_tick_c3", tk[3], 0);
    check("s5_tick_c4", tk[4], 1);
    check("s5_exp_c9",  ex[9], 1);
    check("s5_st_c10",  stv[10], 3);

    idle(2);
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
